multi_zone_home_controller: RTL and testbench

//   Parametrised successor to the single-zone home automation top. Serves N_ZONES zones.

---
 rtl/multi_zone_home_controller.sv | 203 ++++++++++++++++++++
 tb/tb_multi_zone_home_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_zone_home_controller.sv
// Multi-zone home controller: per-zone light timer and thermostat, plus a
// shared security FSM with an entry delay. Inputs are registered once, then
// all state and outputs are registered from those copies.

// One zone: occupancy light with hold timer and a hysteresis thermostat.
module mzhc_zone #(
    parameter int TEMP_W     = 8,
    parameter int HYST       = 2,
    parameter int LIGHT_HOLD = 16,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              motionR,
    input  logic              manualR,
    input  logic              scheduleR,
    input  logic              ecoR,
    input  logic              windowR,
    input  logic [TEMP_W-1:0] curR,
    input  logic [TEMP_W-1:0] desR,
    output logic              lightOn,
    output logic              heaterOn,
    output logic              coolerOn
);
    localparam int TW = TEMP_W + 1;
    // Timer is loaded with H-1 so the trigger cycle plus H-1 countdown cycles give H lit cycles.
    localparam logic [CNT_W-1:0] HOLD_FULL = CNT_W'(LIGHT_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_ECO  = CNT_W'((LIGHT_HOLD >> 1) - 1);
    localparam logic [TW-1:0]    BAND_FULL = TW'(HYST);
    localparam logic [TW-1:0]    BAND_ECO  = TW'(2 * HYST);

    logic [CNT_W-1:0] cnt;
    logic             trigger;
    logic [TW-1:0]    band, cur, des, lo, hi;
    logic             heatNext, coolNext;

    // Thermostat decision in one extra bit so des+band cannot wrap.
    always_comb begin
        trigger  = motionR & scheduleR;
        band     = ecoR ? BAND_ECO : BAND_FULL;
        cur      = {1'b0, curR};
        des      = {1'b0, desR};
        lo       = (des > band) ? des - band : '0;
        hi       = des + band;
        heatNext = heaterOn;
        coolNext = coolerOn;
        if (windowR) begin
            heatNext = 1'b0;
            coolNext = 1'b0;
        end else begin
            if (cur < lo)        heatNext = 1'b1;
            else if (cur >= des) heatNext = 1'b0;
            if (cur > hi)        coolNext = 1'b1;
            else if (cur <= des) coolNext = 1'b0;
        end
    end

    // Light hold timer: trigger reloads, otherwise count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            lightOn <= 1'b0;
        end else begin
            if (trigger)         cnt <= ecoR ? HOLD_ECO : HOLD_FULL;
            else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
            lightOn <= manualR | trigger | (cnt != '0);
        end
    end

    // Heater/cooler registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            heaterOn <= 1'b0;
            coolerOn <= 1'b0;
        end else begin
            heaterOn <= heatNext;
            coolerOn <= coolNext;
        end
    end
endmodule

module multi_zone_home_controller #(
    parameter int N_ZONES     = 4,
    parameter int TEMP_W      = 8,
    parameter int HYST        = 2,
    parameter int LIGHT_HOLD  = 16,
    parameter int ENTRY_DELAY = 8,
    parameter int CNT_W       = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_ZONES-1:0]          motion,
    input  logic [N_ZONES-1:0]          manual_switch,
    input  logic                        schedule_active,
    input  logic [N_ZONES*TEMP_W-1:0]   current_temp,
    input  logic [N_ZONES*TEMP_W-1:0]   desired_temp,
    input  logic                        door_open,
    input  logic                        window_open,
    input  logic                        energy_saving_mode,
    input  logic                        arm_cmd,
    input  logic                        disarm_cmd,
    output logic [N_ZONES-1:0]          light_on,
    output logic [N_ZONES-1:0]          heater_on,
    output logic [N_ZONES-1:0]          cooler_on,
    output logic                        alarm,
    output logic                        armed,
    output logic                        entry_pending
);
    typedef enum logic [1:0] {DISARMED, ARMED, ENTRY, ALARM} secState_t;

    logic [N_ZONES-1:0]        motion_r, manual_switch_r;
    logic [N_ZONES*TEMP_W-1:0] current_temp_r, desired_temp_r;
    logic schedule_active_r, door_open_r, window_open_r;
    logic energy_saving_mode_r, arm_cmd_r, disarm_cmd_r;

    secState_t        state, stateNext;
    logic [CNT_W-1:0] ecnt, ecntNext;

    // Input register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            motion_r             <= '0;
            manual_switch_r      <= '0;
            schedule_active_r    <= 1'b0;
            current_temp_r       <= '0;
            desired_temp_r       <= '0;
            door_open_r          <= 1'b0;
            window_open_r        <= 1'b0;
            energy_saving_mode_r <= 1'b0;
            arm_cmd_r            <= 1'b0;
            disarm_cmd_r         <= 1'b0;
        end else begin
            motion_r             <= motion;
            manual_switch_r      <= manual_switch;
            schedule_active_r    <= schedule_active;
            current_temp_r       <= current_temp;
            desired_temp_r       <= desired_temp;
            door_open_r          <= door_open;
            window_open_r        <= window_open;
            energy_saving_mode_r <= energy_saving_mode;
            arm_cmd_r            <= arm_cmd;
            disarm_cmd_r         <= disarm_cmd;
        end
    end

    // Security state and entry countdown registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= DISARMED;
            ecnt  <= '0;
        end else begin
            state <= stateNext;
            ecnt  <= ecntNext;
        end
    end

    // Security next state; disarm always has priority.
    always_comb begin
        stateNext = state;
        ecntNext  = ecnt;
        case (state)
            DISARMED: if (arm_cmd_r & ~door_open_r & ~window_open_r) stateNext = ARMED;
            ARMED: begin
                if (disarm_cmd_r)                      stateNext = DISARMED;
                else if (window_open_r | (|motion_r))  stateNext = ALARM;
                else if (door_open_r) begin
                    stateNext = ENTRY;
                    ecntNext  = CNT_W'(ENTRY_DELAY - 1);
                end
            end
            ENTRY: begin
                if (disarm_cmd_r)     stateNext = DISARMED;
                else if (ecnt == '0)  stateNext = ALARM;
                else                  ecntNext  = ecnt - CNT_W'(1);
            end
            ALARM: if (disarm_cmd_r) stateNext = DISARMED;
            default: stateNext = DISARMED;
        endcase
    end

    assign alarm         = (state == ALARM);
    assign entry_pending = (state == ENTRY);
    assign armed         = (state != DISARMED);

    for (genvar i = 0; i < N_ZONES; i++) begin : gZone
        mzhc_zone #(
            .TEMP_W(TEMP_W), .HYST(HYST), .LIGHT_HOLD(LIGHT_HOLD), .CNT_W(CNT_W)
        ) uZone (
            .clk      (clk),
            .reset    (reset),
            .motionR  (motion_r[i]),
            .manualR  (manual_switch_r[i]),
            .scheduleR(schedule_active_r),
            .ecoR     (energy_saving_mode_r),
            .windowR  (window_open_r),
            .curR     (current_temp_r[i*TEMP_W +: TEMP_W]),
            .desR     (desired_temp_r[i*TEMP_W +: TEMP_W]),
            .lightOn  (light_on[i]),
            .heaterOn (heater_on[i]),
            .coolerOn (cooler_on[i])
        );
    end
endmodule

// File: tb/tb_multi_zone_home_controller.sv
// Directed bench for multi_zone_home_controller with default parameters.
module tb_multi_zone_home_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  motion, manual_switch;
    logic        schedule_active;
    logic [31:0] current_temp, desired_temp;
    logic        door_open, window_open, energy_saving_mode, arm_cmd, disarm_cmd;
    logic [3:0]  light_on, heater_on, cooler_on;
    logic        alarm, armed, entry_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] cur;
        logic [7:0] des;
        logic       win;
        logic       eco;
        logic       heat;
        logic       cool;
    } vec_t;
    vec_t vecs[20];

    multi_zone_home_controller dut (
        .clk(clk), .reset(reset), .motion(motion), .manual_switch(manual_switch),
        .schedule_active(schedule_active), .current_temp(current_temp),
        .desired_temp(desired_temp), .door_open(door_open), .window_open(window_open),
        .energy_saving_mode(energy_saving_mode), .arm_cmd(arm_cmd), .disarm_cmd(disarm_cmd),
        .light_on(light_on), .heater_on(heater_on), .cooler_on(cooler_on),
        .alarm(alarm), .armed(armed), .entry_pending(entry_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic doArm();
        arm_cmd = 1'b1; tick(); arm_cmd = 1'b0; tick();
    endtask

    task automatic doorPulse();
        door_open = 1'b1; tick(); door_open = 1'b0; tick();
    endtask

    task automatic doDisarm();
        disarm_cmd = 1'b1; tick(); tick(); disarm_cmd = 1'b0; tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, bad, seen;
        vecs[0]  = '{8'd20, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'd17, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'd18, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{8'd19, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{8'd20, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'd21, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'd23, 8'd20, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{8'd22, 8'd20, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'd20, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'd17, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'd17, 8'd20, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'd17, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{8'd20, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{8'd17, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{8'd15, 8'd20, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{8'd24, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{8'd25, 8'd20, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{8'd25, 8'd20, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{8'd0,  8'd1,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{8'd16, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        motion = '0; manual_switch = '0; schedule_active = 1'b0;
        current_temp = {4{8'd50}}; desired_temp = {4{8'd50}};
        door_open = 1'b0; window_open = 1'b0; energy_saving_mode = 1'b0;
        arm_cmd = 1'b0; disarm_cmd = 1'b0;
        tick(); tick();
        chk("rst_light", 32'(light_on), 32'h0);
        chk("rst_heat", 32'(heater_on), 32'h0);
        chk("rst_cool", 32'(cooler_on), 32'h0);
        chk("rst_sec", {29'b0, alarm, armed, entry_pending}, 32'h0);
        reset = 1'b1;
        tick();

        // Light: single motion pulse on zone 2, full and eco hold.
        for (int e = 0; e < 2; e++) begin
            energy_saving_mode = 1'(e);
            motion = 4'b0100; schedule_active = 1'b1;
            tick();
            motion = '0;
            chk("light_latency", 32'(light_on), 32'h0);
            cnt = 0; bad = 0;
            for (int i = 0; i < 24; i++) begin
                tick();
                if (light_on == 4'b0100) cnt++;
                else if (light_on != 4'b0000) bad++;
            end
            chk(e ? "light_hold_eco" : "light_hold", 32'(cnt), e ? 32'd8 : 32'd16);
            chk("light_other_zones", 32'(bad), 32'h0);
        end
        energy_saving_mode = 1'b0; schedule_active = 1'b0;

        // Manual switch lights immediately-after-latency and loads no timer.
        manual_switch = 4'b0010; tick();
        chk("manual_latency", 32'(light_on), 32'h0);
        tick();
        chk("manual_on", 32'(light_on), 32'h2);
        manual_switch = '0; tick(); tick();
        chk("manual_off", 32'(light_on), 32'h0);

        // Thermostat table on zone 0; other zones sit at setpoint.
        for (int v = 0; v < 20; v++) begin
            current_temp = {8'd50, 8'd50, 8'd50, vecs[v].cur};
            desired_temp = {8'd50, 8'd50, 8'd50, vecs[v].des};
            window_open = vecs[v].win;
            energy_saving_mode = vecs[v].eco;
            tick(); tick();
            chk($sformatf("heat_v%0d", v), 32'(heater_on), {31'b0, vecs[v].heat});
            chk($sformatf("cool_v%0d", v), 32'(cooler_on), {31'b0, vecs[v].cool});
        end

        // Entry delay expiring into a latched alarm.
        doArm();
        chk("armed", {30'b0, armed, alarm}, 32'h2);
        doorPulse();
        cnt = 0;
        while (entry_pending && cnt < 20) begin cnt++; tick(); end
        chk("entry_len", 32'(cnt), 32'd8);
        chk("entry_alarm", {30'b0, alarm, armed}, 32'h3);
        tick(); tick(); tick();
        chk("alarm_latched", 32'(alarm), 32'h1);
        doDisarm();
        chk("disarm_alarm", {30'b0, alarm, armed}, 32'h0);

        // Disarm during ENTRY cycle 5.
        doArm();
        doorPulse();
        chk("entry_start", 32'(entry_pending), 32'h1);
        tick(); tick(); tick();
        disarm_cmd = 1'b1; tick(); tick(); disarm_cmd = 1'b0;
        chk("entry_disarm", {30'b0, armed, entry_pending}, 32'h0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (alarm) seen = 1; end
        chk("entry_no_alarm", 32'(seen), 32'h0);

        // Arm refused with window open.
        window_open = 1'b1; arm_cmd = 1'b1; tick(); tick(); tick();
        chk("arm_refused", 32'(armed), 32'h0);
        arm_cmd = 1'b0; window_open = 1'b0; tick(); tick();
        chk("arm_refused2", 32'(armed), 32'h0);

        // Motion with disarm: disarm wins.
        doArm();
        motion = 4'b0001; disarm_cmd = 1'b1; tick(); tick();
        motion = '0; disarm_cmd = 1'b0;
        chk("disarm_priority", {30'b0, alarm, armed}, 32'h0);
        tick();

        // Motion alone in ARMED.
        doArm();
        chk("rearmed", 32'(armed), 32'h1);
        motion = 4'b0010; tick();
        chk("motion_latency", 32'(alarm), 32'h0);
        motion = '0; tick();
        chk("motion_alarm", 32'(alarm), 32'h1);
        doDisarm();

        // Async reset mid-ENTRY and mid-light-hold.
        doArm();
        doorPulse();
        motion = 4'b1000; schedule_active = 1'b1; tick();
        motion = '0; tick();
        chk("pre_rst_light", 32'(light_on), 32'h8);
        chk("pre_rst_entry", 32'(entry_pending), 32'h1);
        chk("pre_rst_heat", 32'(heater_on), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_light", 32'(light_on), 32'h0);
        chk("async_heat_cool", {heater_on, cooler_on}, 32'h0);
        chk("async_sec", {29'b0, alarm, armed, entry_pending}, 32'h0);
        @(negedge clk);
        reset = 1'b1; schedule_active = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (armed || light_on != 4'b0000) seen = 1;
        end
        chk("post_rst_idle", 32'(seen), 32'h0);
        doArm();
        chk("post_rst_arm", 32'(armed), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
